pll_lock_controller: RTL

Sequences reset and lock qualification for the board's general-purpose PLL (10 MHz reference in, 10 MHz and 118 MHz out) and is the single source of PLL-derived readiness for downstream logic. Runs on the free-running reference clock. Drives the PLL reset, synchronises and debounces the PLL lock flag, retries on lock timeout, and re-sequences automatically on lock loss. Exposes status and counters to the register interface.

---
 rtl/pll_ctrl_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_controller.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller: state encoding, default
// timing constants (also used by the register map) and counter sizing.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET_HOLD   = 3'd0,
      ST_WAIT_LOCK    = 3'd1,
      ST_STABLE_CHECK = 3'd2,
      ST_RUN          = 3'd3,
      ST_FAULT        = 3'd4
   } pll_state_t;

   localparam int unsigned DEF_RST_HOLD_CYCLES     = 100;
   localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1000;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 100000;
   localparam int unsigned DEF_RETRY_LIMIT         = 15;
   localparam int          DEF_LOSS_CNT_WIDTH      = 8;

   // One spare bit above the largest terminal count.
   function automatic int cyc_cnt_width(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser with synchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_controller.sv
// PLL reset sequencing and lock qualification on the free-running refclk;
// sole source of PLL-derived readiness and the matching domain reset.
module pll_lock_controller
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
   parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int unsigned RETRY_LIMIT         = DEF_RETRY_LIMIT,
   parameter int          LOSS_CNT_WIDTH      = DEF_LOSS_CNT_WIDTH
) (
   input  logic                      refclk,
   input  logic                      rst,
   input  logic                      sw_reset_req,
   input  logic                      pll_locked_i,
   output logic                      pll_rst_o,
   output logic                      pll_ready_o,
   output logic                      sys_rst_o,
   output logic                      fault_o,
   output logic [2:0]                state_o,
   output logic [7:0]                retry_cnt_o,
   output logic [LOSS_CNT_WIDTH-1:0] lock_loss_cnt_o
);

   // state           | meaning
   // RESET_HOLD      | PLL held in reset for RST_HOLD_CYCLES
   // WAIT_LOCK       | reset released, waiting for lock or timeout
   // STABLE_CHECK    | lock seen, qualifying LOCK_STABLE_CYCLES of steady lock
   // RUN             | PLL ready, downstream domains out of reset
   // FAULT           | retry limit hit, PLL held in reset until sw_reset_req

   localparam int CW = cyc_cnt_width(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES);
   localparam logic [CW-1:0] HOLD_TC    = CW'(RST_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_TC  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_TC = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    RETRY_MAX  = 8'(RETRY_LIMIT);

   pll_state_t    state, state_nxt;
   logic [CW-1:0] cnt;
   logic [7:0]    retry_cnt, retry_nxt;
   logic          loss_inc;
   logic          locked_s, locked_q, sw_q;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked_i),
      .q   (locked_s)
   );

   // Registering both FSM inputs keeps a request and a lock drop in the same
   // cycle aligned, so the loss is still counted when they coincide.
   always_ff @(posedge refclk) begin
      if (rst) begin
         locked_q <= 1'b0;
         sw_q     <= 1'b0;
      end else begin
         locked_q <= locked_s;
         sw_q     <= sw_reset_req;
      end
   end

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      loss_inc  = 1'b0;
      unique case (state)
         ST_RESET_HOLD: begin
            if (cnt == HOLD_TC) state_nxt = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (locked_q) begin
               state_nxt = ST_STABLE_CHECK;
            end else if (cnt == TIMEOUT_TC) begin
               retry_nxt = retry_cnt + 8'd1;
               state_nxt = (retry_nxt == RETRY_MAX) ? ST_FAULT : ST_RESET_HOLD;
            end
         end
         ST_STABLE_CHECK: begin
            if (!locked_q) begin
               state_nxt = ST_WAIT_LOCK;
            end else if (cnt == STABLE_TC) begin
               state_nxt = ST_RUN;
               retry_nxt = 8'd0;
            end
         end
         ST_RUN: begin
            if (!locked_q) begin
               loss_inc  = 1'b1;
               state_nxt = ST_RESET_HOLD;
            end
         end
         ST_FAULT: ;
         default: state_nxt = ST_RESET_HOLD;
      endcase
      if (sw_q) begin
         state_nxt = ST_RESET_HOLD;
         retry_nxt = (state == ST_FAULT) ? 8'd0 : retry_cnt;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state           <= ST_RESET_HOLD;
         cnt             <= '0;
         retry_cnt       <= 8'd0;
         lock_loss_cnt_o <= '0;
         pll_rst_o       <= 1'b1;
         pll_ready_o     <= 1'b0;
         sys_rst_o       <= 1'b1;
         fault_o         <= 1'b0;
      end else begin
         state     <= state_nxt;
         retry_cnt <= retry_nxt;
         if (state_nxt != state || sw_q) begin
            cnt <= '0;
         end else if (state != ST_RUN && state != ST_FAULT) begin
            cnt <= cnt + CW'(1);
         end
         if (loss_inc && lock_loss_cnt_o != '1) begin
            lock_loss_cnt_o <= lock_loss_cnt_o + LOSS_CNT_WIDTH'(1);
         end
         pll_rst_o   <= (state_nxt == ST_RESET_HOLD) || (state_nxt == ST_FAULT);
         pll_ready_o <= (state_nxt == ST_RUN);
         sys_rst_o   <= (state_nxt != ST_RUN);
         fault_o     <= (state_nxt == ST_FAULT);
      end
   end

   assign state_o     = state;
   assign retry_cnt_o = retry_cnt;

endmodule
